// File: rtl/packet_loss_window_ctrl.sv
// ---------------------------------------------------------------------------
// packet_loss_window_ctrl
//
// Measurement-window controller for the four-lane packet loss counter bank.
// A timer counts fixed windows of WINDOW_CYCLES clocks. At each window end
// the packed lane counts are captured, the counter bank is cleared with a
// one-cycle pulse, and a per-window report is published: snapshot, per-lane
// saturating running totals, per-lane threshold alarms and a completed-window
// count.
//
// Window sequence: IDLE -> COUNT (WINDOW_CYCLES cycles) -> CAPTURE -> CLEAR
// -> REPORT -> COUNT ... ; a drop of enable during COUNT aborts to IDLE.
//
// Build option:
//   STICKY_ALARM_EN  when defined, alarm bits are set-only and cleared only
//                    by clear_totals or reset_n; otherwise each report
//                    rewrites the alarm vector.
//
// Ports:
//   clk               system clock
//   reset_n           asynchronous active-low reset
//   enable            level, 1 = run windows, 0 = idle
//   clear_totals      sync pulse, zeroes totals, window_count (and sticky alarms)
//   error_count[31:0] packed lane counts, lane i = bits [8i+7:8i]
//   en_reset_counter  one-cycle clear pulse to the counter bank
//   snapshot[31:0]    error_count captured at the last window end
//   snapshot_valid    one-cycle pulse, snapshot/totals/alarm/window_count
//                     hold the new report values in this cycle
//   alarm[3:0]        per-lane threshold alarm
//   window_count[15:0] completed windows, wraps 0xFFFF -> 0
//   rd_sel[1:0]       lane select for rd_total
//   rd_total          combinational read of the running total of lane rd_sel
// ---------------------------------------------------------------------------
module packet_loss_window_ctrl #(
    parameter logic [31:0] WINDOW_CYCLES = 32'd27000000,
    parameter int          TOTAL_W       = 16,
    parameter logic [7:0]  ALARM_THRESH  = 8'd8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               clear_totals,
    input  logic [31:0]        error_count,
    output logic               en_reset_counter,
    output logic [31:0]        snapshot,
    output logic               snapshot_valid,
    output logic [3:0]         alarm,
    output logic [15:0]        window_count,
    input  logic [1:0]         rd_sel,
    output logic [TOTAL_W-1:0] rd_total
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COUNT   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_CLEAR   = 3'd3,
        ST_REPORT  = 3'd4
    } state_e;

    localparam logic [31:0] LAST_TICK = WINDOW_CYCLES - 32'd1;

    state_e               state_q, state_d;
    logic [31:0]          timer_q, timer_d;
    logic                 en_reset_counter_q, en_reset_counter_d;
    logic [31:0]          snapshot_q, snapshot_d;
    logic                 snapshot_valid_q, snapshot_valid_d;
    logic [3:0]           alarm_q, alarm_d;
    logic [15:0]          window_count_q, window_count_d;
    logic [TOTAL_W-1:0]   total_q [4];
    logic [TOTAL_W-1:0]   total_d [4];
    logic                 report_upd_s;
    logic [3:0]           lane_hit_s;

    // Zero-extended lane add into a running total, clamped at all-ones.
    function automatic logic [TOTAL_W-1:0] sat_add(
        input logic [TOTAL_W-1:0] acc,
        input logic [7:0]         lane
    );
        logic [TOTAL_W:0] sum;
        sum = {1'b0, acc} + {{(TOTAL_W-7){1'b0}}, lane};
        if (sum[TOTAL_W]) begin
            sat_add = {TOTAL_W{1'b1}};
        end else begin
            sat_add = sum[TOTAL_W-1:0];
        end
    endfunction

    // Next-state and window timer.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            ST_IDLE: begin
                timer_d = 32'd0;
                if (enable) begin
                    state_d = ST_COUNT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COUNT: begin
                // An abort takes priority over a window end in the same cycle.
                if (!enable) begin
                    state_d = ST_IDLE;
                    timer_d = 32'd0;
                end else if (timer_q == LAST_TICK) begin
                    state_d = ST_CAPTURE;
                    timer_d = 32'd0;
                end else begin
                    state_d = ST_COUNT;
                    timer_d = timer_q + 32'd1;
                end
            end
            ST_CAPTURE: begin
                state_d = ST_CLEAR;
                timer_d = 32'd0;
            end
            ST_CLEAR: begin
                state_d = ST_REPORT;
                timer_d = 32'd0;
            end
            ST_REPORT: begin
                timer_d = 32'd0;
                if (enable) begin
                    state_d = ST_COUNT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = 32'd0;
            end
        endcase
    end

    // Registered outputs: each one is computed for the state being entered,
    // so the pulse and the report values appear in that state's cycle.
    always_comb begin
        en_reset_counter_d = (state_q == ST_CAPTURE);
        snapshot_valid_d   = (state_q == ST_CLEAR);
        if (state_q == ST_CAPTURE) begin
            snapshot_d = error_count;
        end else begin
            snapshot_d = snapshot_q;
        end
    end

    // The report is committed on the edge entering REPORT, from the snapshot
    // taken one cycle earlier.
    assign report_upd_s = (state_q == ST_CLEAR);

    // Per-lane threshold hits of the captured snapshot.
    always_comb begin
        lane_hit_s = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            lane_hit_s[i] = (snapshot_q[8*i +: 8] >= ALARM_THRESH);
        end
    end

    // Running totals and window count; clear_totals beats a coincident report.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            if (clear_totals) begin
                total_d[i] = {TOTAL_W{1'b0}};
            end else if (report_upd_s) begin
                total_d[i] = sat_add(total_q[i], snapshot_q[8*i +: 8]);
            end else begin
                total_d[i] = total_q[i];
            end
        end
        if (clear_totals) begin
            window_count_d = 16'd0;
        end else if (report_upd_s) begin
            window_count_d = window_count_q + 16'd1;
        end else begin
            window_count_d = window_count_q;
        end
    end

`ifdef STICKY_ALARM_EN
    // Set-only alarms; only clear_totals (or reset) drops them.
    always_comb begin
        if (clear_totals) begin
            alarm_d = 4'b0000;
        end else if (report_upd_s) begin
            alarm_d = alarm_q | lane_hit_s;
        end else begin
            alarm_d = alarm_q;
        end
    end
`else
    // Alarms reflect the most recent window only.
    always_comb begin
        if (report_upd_s) begin
            alarm_d = lane_hit_s;
        end else begin
            alarm_d = alarm_q;
        end
    end
`endif

    // State, timer and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q            <= ST_IDLE;
            timer_q            <= 32'd0;
            en_reset_counter_q <= 1'b0;
            snapshot_q         <= 32'd0;
            snapshot_valid_q   <= 1'b0;
            alarm_q            <= 4'b0000;
            window_count_q     <= 16'd0;
            for (int i = 0; i < 4; i++) begin
                total_q[i] <= {TOTAL_W{1'b0}};
            end
        end else begin
            state_q            <= state_d;
            timer_q            <= timer_d;
            en_reset_counter_q <= en_reset_counter_d;
            snapshot_q         <= snapshot_d;
            snapshot_valid_q   <= snapshot_valid_d;
            alarm_q            <= alarm_d;
            window_count_q     <= window_count_d;
            for (int i = 0; i < 4; i++) begin
                total_q[i] <= total_d[i];
            end
        end
    end

    assign en_reset_counter = en_reset_counter_q;
    assign snapshot         = snapshot_q;
    assign snapshot_valid   = snapshot_valid_q;
    assign alarm            = alarm_q;
    assign window_count     = window_count_q;
    assign rd_total         = total_q[rd_sel];

endmodule

// File: tb/tb_packet_loss_window_ctrl.sv
module tb_packet_loss_window_ctrl;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        clear_totals;
    logic [31:0] error_count;
    logic        en_reset_counter;
    logic [31:0] snapshot;
    logic        snapshot_valid;
    logic [3:0]  alarm;
    logic [15:0] window_count;
    logic [1:0]  rd_sel;
    logic [15:0] rd_total;

    int n_cmp;
    int n_err;

    packet_loss_window_ctrl #(
        .WINDOW_CYCLES (32'd10),
        .TOTAL_W       (16),
        .ALARM_THRESH  (8'd8)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .enable           (enable),
        .clear_totals     (clear_totals),
        .error_count      (error_count),
        .en_reset_counter (en_reset_counter),
        .snapshot         (snapshot),
        .snapshot_valid   (snapshot_valid),
        .alarm            (alarm),
        .window_count     (window_count),
        .rd_sel           (rd_sel),
        .rd_total         (rd_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step until en_reset_counter is seen (bounded); n = steps taken.
    task automatic wait_en(output int n, output int sv_seen);
        n = 0;
        sv_seen = 0;
        do begin
            step();
            n++;
            if (snapshot_valid) sv_seen++;
        end while (!en_reset_counter && n < 100);
    endtask

    // Present error_count, run to the next window end, land in REPORT.
    task automatic window(input logic [31:0] ec);
        int n;
        int s;
        error_count = ec;
        wait_en(n, s);
        step();
    endtask

    task automatic check_totals(input string tag, input logic [15:0] t0, input logic [15:0] t1,
                                input logic [15:0] t2, input logic [15:0] t3);
        logic [15:0] exp_t [4];
        exp_t[0] = t0; exp_t[1] = t1; exp_t[2] = t2; exp_t[3] = t3;
        for (int i = 0; i < 4; i++) begin
            rd_sel = i[1:0];
            #1;
            check_val($sformatf("%s_lane%0d", tag, i), {16'd0, rd_total}, {16'd0, exp_t[i]});
        end
    endtask

    task automatic pulse_clear();
        clear_totals = 1'b1;
        step();
        clear_totals = 1'b0;
    endtask

    initial begin
        int n;
        int s;
        int en_seen;
        int sv_seen;
        n_cmp = 0;
        n_err = 0;
        reset_n = 1'b0;
        enable = 1'b0;
        clear_totals = 1'b0;
        error_count = 32'd0;
        rd_sel = 2'd0;

        // Reset state
        #3;
        check_val("rst_en", {31'd0, en_reset_counter}, 32'd0);
        check_val("rst_snap", snapshot, 32'd0);
        check_val("rst_sv", {31'd0, snapshot_valid}, 32'd0);
        check_val("rst_alarm", {28'd0, alarm}, 32'd0);
        check_val("rst_wc", {16'd0, window_count}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // Basic window: 11 steps from COUNT entry to the clear pulse
        enable = 1'b1;
        error_count = 32'h03020100;
        step();
        wait_en(n, s);
        check_val("first_en_latency", n, 32'd11);
        check_val("no_sv_before_en", s, 32'd0);
        check_val("snap_at_clear", snapshot, 32'h03020100);
        step();
        check_val("en_one_cycle", {31'd0, en_reset_counter}, 32'd0);
        check_val("sv_report", {31'd0, snapshot_valid}, 32'd1);
        check_val("wc_first", {16'd0, window_count}, 32'd1);
        check_totals("tot_first", 16'd0, 16'd1, 16'd2, 16'd3);
        wait_en(n, s);
        check_val("en_period", n + 1, 32'd13);

        // Asynchronous reset mid-COUNT
        step();
        step();
        step();
        #2;
        reset_n = 1'b0;
        enable = 1'b0;
        #1;
        check_val("arst_snap", snapshot, 32'd0);
        check_val("arst_wc", {16'd0, window_count}, 32'd0);
        check_val("arst_sv", {31'd0, snapshot_valid}, 32'd0);
        check_val("arst_en", {31'd0, en_reset_counter}, 32'd0);
        check_totals("arst_tot", 16'd0, 16'd0, 16'd0, 16'd0);
        reset_n = 1'b1;
        en_seen = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (en_reset_counter) en_seen++;
        end
        check_val("idle_no_en", en_seen, 32'd0);
        enable = 1'b1;
        step();
        wait_en(n, s);
        check_val("post_rst_latency", n, 32'd11);
        step();
        check_val("post_rst_wc", {16'd0, window_count}, 32'd1);

        // Saturation: 256*0xFF + 0xF0 = 0xFFF0
        pulse_clear();
        check_val("clr_wc", {16'd0, window_count}, 32'd0);
        error_count = 32'h000000FF;
        for (int i = 0; i < 256; i++) wait_en(n, s);
        window(32'h000000F0);
        check_totals("sat_pre", 16'hFFF0, 16'd0, 16'd0, 16'd0);
        window(32'h00000020);
        check_totals("sat_clamp", 16'hFFFF, 16'd0, 16'd0, 16'd0);
        window(32'h00000001);
        check_totals("sat_hold", 16'hFFFF, 16'd0, 16'd0, 16'd0);
        check_val("wc_259", {16'd0, window_count}, 32'd259);

        // Alarm threshold (lane1 = 7 just below, lane2 = 8 at threshold)
        pulse_clear();
        check_val("alarm_clr0", {28'd0, alarm}, 32'd0);
        window(32'h00080700);
        check_val("alarm_hit", {28'd0, alarm}, 32'h4);
        check_totals("alarm_tot", 16'd0, 16'd7, 16'd8, 16'd0);
        window(32'h00000000);
`ifdef STICKY_ALARM_EN
        check_val("alarm_next", {28'd0, alarm}, 32'h4);
`else
        check_val("alarm_next", {28'd0, alarm}, 32'h0);
`endif
        check_val("alarm_wc", {16'd0, window_count}, 32'd2);
        pulse_clear();
        check_val("alarm_clr", {28'd0, alarm}, 32'd0);
        check_val("alarm_clr_wc", {16'd0, window_count}, 32'd0);

        // Abort at timer=5, then a full window restarts from 0
        for (int i = 0; i < 5; i++) step();
        enable = 1'b0;
        en_seen = 0;
        sv_seen = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (en_reset_counter) en_seen++;
            if (snapshot_valid) sv_seen++;
        end
        check_val("abort_no_en", en_seen, 32'd0);
        check_val("abort_no_sv", sv_seen, 32'd0);
        enable = 1'b1;
        step();
        wait_en(n, s);
        check_val("restart_latency", n, 32'd11);
        step();
        check_val("restart_wc", {16'd0, window_count}, 32'd1);

        // clear_totals coincident with the report update
        error_count = 32'h01010101;
        wait_en(n, s);
        clear_totals = 1'b1;
        step();
        clear_totals = 1'b0;
        check_val("coinc_sv", {31'd0, snapshot_valid}, 32'd1);
        check_val("coinc_snap", snapshot, 32'h01010101);
        check_val("coinc_wc", {16'd0, window_count}, 32'd0);
        check_totals("coinc_tot", 16'd0, 16'd0, 16'd0, 16'd0);
        window(32'h01010101);
        check_totals("after_coinc", 16'd1, 16'd1, 16'd1, 16'd1);
        check_val("after_coinc_wc", {16'd0, window_count}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
